// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl
// Run-control for the serial pattern detector. Holds a programmable PW-bit
// pattern and a match target. Once armed, it looks for overlapping
// occurrences of the pattern in the qualified serial stream, counts the
// matches, and raises done when the target count is reached.

module pattern_detect_ctrl #(
   parameter int            PW      = 4,
   parameter int            CW      = 8,
   parameter logic [PW-1:0] PAT_RST = 4'b0110
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_pattern,
   input  logic [CW-1:0] cfg_target,
   input  logic          start,
   input  logic          abort,
   input  logic          din_valid,
   input  logic          din_bit,
   output logic          busy,
   output logic          match_pulse,
   output logic [CW-1:0] match_count,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   localparam int            FW        = $clog2(PW) + 1;
   localparam logic [FW-1:0] FILL_LAST = FW'(PW - 1);

   state_t        state;
   logic [PW-1:0] pattern;
   logic [CW-1:0] target;
   logic [PW-2:0] sreg;
   logic [FW-1:0] fill;

   logic [PW-1:0] window;
   logic          hit;
   logic [CW-1:0] count_inc;
   logic          hit_target;

   // Candidate window, match decode and saturating next count for the current bit.
   always_comb begin
      window     = {sreg[PW-2:0], din_bit};
      hit        = (window == pattern);
      count_inc  = (&match_count) ? match_count : match_count + 1'b1;
      hit_target = (target != '0) && (count_inc == target);
   end

   // Control FSM with registered outputs; abort has priority over any bit handling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         pattern     <= PAT_RST;
         target      <= '0;
         sreg        <= '0;
         fill        <= '0;
         busy        <= 1'b0;
         match_pulse <= 1'b0;
         match_count <= '0;
         done        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // read in this block sees the pre-edge value and later assignments
         // below (e.g. state <= S_DONE) cleanly override earlier defaults.
         match_pulse <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               // Config lands on the same edge as start, so the new run uses it.
               if (cfg_we) begin
                  pattern <= cfg_pattern;
                  target  <= cfg_target;
               end
               if (start && !abort) begin
                  state       <= S_ARM;
                  sreg        <= '0;
                  fill        <= '0;
                  match_count <= '0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            S_ARM, S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (din_valid) begin
                  sreg <= window[PW-2:0];
                  if (state == S_ARM && fill != FILL_LAST) begin
                     fill <= fill + 1'b1;
                  end else begin
                     // Window is full from here on: this bit is compared.
                     state <= S_RUN;
                     if (hit) begin
                        match_pulse <= 1'b1;
                        match_count <= count_inc;
                        if (hit_target) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                           busy  <= 1'b0;
                        end
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// tb_pattern_detect_ctrl
// Directed scenarios plus a randomized phase, checked cycle by cycle against a
// behavioural model. Two instances share the stimulus: the default one (CW=8)
// and a narrow one (CW=2) whose counter saturates quickly.

module tb_pattern_detect_ctrl;

   localparam int PW = 4;

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic [3:0] cfg_pattern;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       din_valid;
   logic       din_bit;

   logic       busy,   busy_s;
   logic       match_pulse, pulse_s;
   logic [7:0] match_count;
   logic [1:0] count_s;
   logic       done,   done_s;

   int n_vec;
   int n_err;

   pattern_detect_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .din_valid   (din_valid),
      .din_bit     (din_bit),
      .busy        (busy),
      .match_pulse (match_pulse),
      .match_count (match_count),
      .done        (done)
   );

   pattern_detect_ctrl #(.PW(4), .CW(2), .PAT_RST(4'b0110)) dut_s (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_target  (cfg_target[1:0]),
      .start       (start),
      .abort       (abort),
      .din_valid   (din_valid),
      .din_bit     (din_bit),
      .busy        (busy_s),
      .match_pulse (pulse_s),
      .match_count (count_s),
      .done        (done_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (index 0: CW=8, index 1: CW=2) -------
   bit m_run[2];
   bit m_fin[2];
   bit m_pulse[2];
   int m_cnt[2];
   int m_pat[2];
   int m_tgt[2];
   int m_win[2];
   int m_nb[2];

   function automatic int cap(input int i);
      return (i == 0) ? 255 : 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 0; m_fin[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0;
         m_pat[i] = 6; m_tgt[i] = 0; m_win[i] = 0; m_nb[i] = 0;
      end
   endtask

   // One rising edge: a run accepts bits until abort or target; otherwise
   // the block only listens to config and start.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         m_pulse[i] = 0;
         if (m_run[i]) begin
            if (abort) begin
               m_run[i] = 0;
            end else if (din_valid) begin
               m_win[i] = ((m_win[i] << 1) | int'(din_bit)) & 15;
               m_nb[i]++;
               if (m_nb[i] >= PW && m_win[i] == m_pat[i]) begin
                  m_pulse[i] = 1;
                  if (m_cnt[i] < cap(i)) m_cnt[i]++;
                  if (m_tgt[i] != 0 && m_cnt[i] == m_tgt[i]) begin
                     m_run[i] = 0;
                     m_fin[i] = 1;
                  end
               end
            end
         end else begin
            if (cfg_we) begin
               m_pat[i] = int'(cfg_pattern);
               m_tgt[i] = int'(cfg_target) % (cap(i) + 1);
            end
            if (start && !abort) begin
               m_run[i] = 1; m_fin[i] = 0; m_cnt[i] = 0;
               m_win[i] = 0; m_nb[i] = 0;
            end
         end
      end
   endtask

   // ---------------- checking ----------------------------------------------
   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("busy",    busy,        m_run[0]);
      check("pulse",   match_pulse, m_pulse[0]);
      check("count",   match_count, m_cnt[0]);
      check("done",    done,        m_fin[0]);
      check("busy_s",  busy_s,      m_run[1]);
      check("pulse_s", pulse_s,     m_pulse[1]);
      check("count_s", count_s,     m_cnt[1]);
      check("done_s",  done_s,      m_fin[1]);
   endtask

   // Drive one cycle of inputs, clock it, update the model, sample 1ns later.
   task automatic cycle(input bit we, input logic [3:0] pat, input logic [7:0] tgt,
                        input bit st, input bit ab, input bit v, input bit b);
      cfg_we = we; cfg_pattern = pat; cfg_target = tgt;
      start = st; abort = ab; din_valid = v; din_bit = b;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle();
      cycle(0, 4'h0, 8'h0, 0, 0, 0, 0);
   endtask

   // Feed n bits MSB first, optionally with an invalid cycle after each bit.
   task automatic feed(input logic [15:0] bits, input int n, input bit gaps);
      for (int k = n - 1; k >= 0; k--) begin
         cycle(0, 4'h0, 8'h0, 0, 0, 1, bits[k]);
         if (gaps) idle();
      end
   endtask

   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check("rst_count_now", match_count, 0);
      #2 rst = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b0;
      cfg_we = 0; cfg_pattern = 0; cfg_target = 0;
      start = 0; abort = 0; din_valid = 0; din_bit = 0;
      model_reset();
      #2;
      check_outputs();
      #10 rst = 1'b1;

      // 1: default pattern 0110, target 1
      cycle(1, 4'b0110, 8'd1, 1, 0, 0, 0);
      feed(16'b0110, 4, 0);
      check("t1_pulse", match_pulse, 1);
      check("t1_done",  done, 1);
      check("t1_busy",  busy, 0);
      idle();
      check("t1_pulse_once", match_pulse, 0);
      check("t1_done_hold",  done, 1);

      // 2: overlap, free-run
      cycle(1, 4'b0110, 8'd0, 1, 0, 0, 0);
      feed(16'b0110110, 7, 0);
      check("t2_count", match_count, 2);
      check("t2_busy",  busy, 1);
      cycle(0, 4'h0, 8'h0, 0, 1, 0, 0);

      // 3: same stream with gaps
      cycle(0, 4'h0, 8'h0, 1, 0, 0, 0);
      feed(16'b011, 3, 1);
      check("t3_no_early", match_count, 0);
      feed(16'b0110, 4, 1);
      check("t3_count", match_count, 2);
      cycle(0, 4'h0, 8'h0, 0, 1, 0, 0);

      // 4: reconfig in IDLE, ignored in RUN
      cycle(1, 4'b1011, 8'd3, 0, 0, 0, 0);
      cycle(0, 4'h0, 8'h0, 1, 0, 0, 0);
      feed(16'b1011, 4, 0);
      cycle(1, 4'b0000, 8'd1, 1, 0, 1, 0);
      feed(16'b11011, 5, 0);
      check("t4_count", match_count, 3);
      check("t4_done",  done, 1);
      feed(16'b1011, 4, 0);
      check("t4_after", match_count, 3);

      // 5: abort on the matching bit, then abort+start in IDLE
      cycle(0, 4'h0, 8'h0, 1, 0, 0, 0);
      feed(16'b101101, 6, 0);
      check("t5_pre", match_count, 1);
      cycle(0, 4'h0, 8'h0, 0, 1, 1, 1);
      check("t5_no_pulse", match_pulse, 0);
      check("t5_kept",     match_count, 1);
      check("t5_idle",     busy, 0);
      check("t5_no_done",  done, 0);
      cycle(0, 4'h0, 8'h0, 1, 1, 0, 0);
      check("t5_no_arm", busy, 0);
      idle();

      // 6: saturation on the narrow instance, then async reset mid-stream
      cycle(1, 4'b0110, 8'd0, 1, 0, 0, 0);
      feed(16'h6DB6, 16, 0);
      check("t6_count",   match_count, 5);
      check("t6_count_s", count_s, 3);
      check("t6_busy_s",  busy_s, 1);
      feed(16'b11, 2, 0);
      async_reset();
      idle();

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom % 16) == 0, 4'($urandom), 8'($urandom % 6),
               ($urandom % 8) == 0, ($urandom % 32) == 0,
               ($urandom % 4) != 0, 1'($urandom));
         if (($urandom % 600) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
